// File: rtl/fifo_param_flowctl.sv
// Parameterised synchronous FIFO with registered pop data, programmable almost-full/empty
// thresholds, hysteresis pause output and sticky overflow/underflow flags.
module fifo_param_flowctl #(
    parameter int DATA_SIZE = 10,
    parameter int DEPTH     = 8,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [DATA_SIZE-1:0] data_in_push,
    input  logic                 read,
    input  logic [CNT_W-1:0]     af_thresh,
    input  logic [CNT_W-1:0]     ae_thresh,
    input  logic [CNT_W-1:0]     pause_hi,
    input  logic [CNT_W-1:0]     pause_lo,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 pop_valid,
    output logic [CNT_W-1:0]     data_count,
    output logic                 fifo_empty,
    output logic                 Fifo_full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic                 fifo_pause,
    output logic                 err_overflow,
    output logic                 err_underflow,
    output logic                 fifo_error
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [DATA_SIZE-1:0] data_out_reg;
    logic                 pop_valid_reg;
    logic                 pause_reg, pause_next;
    logic                 ovf_reg, udf_reg;

    logic push_ok;
    logic pop_ok;
    logic empty_w;
    logic full_w;

    assign empty_w = (count_reg == '0);
    assign full_w  = (count_reg == CNT_W'(DEPTH));

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign push_ok = write & (~full_w | read);
    assign pop_ok  = read & ~empty_w;

    // Depth need not be a power of two, so pointers wrap by explicit compare.
    assign wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    assign rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        pause_next = pause_reg;
        if (count_next >= pause_hi) begin
            pause_next = 1'b1;
        end else if (count_next <= pause_lo) begin
            pause_next = 1'b0;
        end
    end

    // Storage has no reset; only valid words between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr_reg] <= data_in_push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            pop_valid_reg <= 1'b0;
            pause_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            udf_reg       <= 1'b0;
        end else begin
            count_reg     <= count_next;
            pause_reg     <= pause_next;
            pop_valid_reg <= pop_ok;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_next;
            end
            if (pop_ok) begin
                rd_ptr_reg   <= rd_ptr_next;
                data_out_reg <= mem[rd_ptr_reg];
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            if (write && !push_ok) begin
                ovf_reg <= 1'b1;
            end else if (err_clr) begin
                ovf_reg <= 1'b0;
            end
            if (read && empty_w) begin
                udf_reg <= 1'b1;
            end else if (err_clr) begin
                udf_reg <= 1'b0;
            end
        end
    end

    assign data_out_pop  = data_out_reg;
    assign pop_valid     = pop_valid_reg;
    assign data_count    = count_reg;
    assign fifo_empty    = empty_w;
    assign Fifo_full     = full_w;
    assign almost_empty  = ~empty_w && (count_reg <= ae_thresh);
    assign almost_full   = (count_reg >= af_thresh);
    assign fifo_pause    = pause_reg;
    assign err_overflow  = ovf_reg;
    assign err_underflow = udf_reg;
    assign fifo_error    = ovf_reg | udf_reg;

endmodule
